// File: rtl/pause_pkg.sv
// Shared state encoding and default timing constants for the pause/frame-step controller.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ARM    = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } pause_state_e;

  // Defaults assume a 12 MHz clk_sys: 10 ms debounce, 100 ms vblank wait.
  localparam int DEBOUNCE_CYC_DEF   = 120000;
  localparam int VB_TIMEOUT_CYC_DEF = 1200000;

endpackage

// File: rtl/pause_debounce.sv
// Button conditioning: 2-FF synchronizer, stable-level debouncer, single-cycle press pulse.
// A button already held when reset releases is ignored until it has been seen released.
module pause_debounce
  import pause_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_1;
  logic          sync_2;
  logic [1:0]    sync_vld;
  logic          armed;
  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync_2 != level) && (cnt == CW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
      level    <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_1   <= btn_raw;
      sync_2   <= sync_1;
      sync_vld <= {sync_vld[0], 1'b1};
      // sync_2 holds a real sample only once sync_vld[1] is set
      if (sync_vld[1] && !sync_2) armed <= 1'b1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press <= flip && sync_2 && armed;
    end
  end

endmodule

// File: rtl/pause_frame_ctrl.sv
// Pause / frame-step sequencer: pauses the core on the next vblank (or after a timeout).
// Optional frame stepping is built in when PAUSE_FRAME_STEP_EN is defined.
//
// state  | meaning
// RUN    | core running, waiting for pause button
// ARM    | pause requested, waiting for vblank or timeout
// PAUSED | core held, pause_request asserted
// STEP   | running one frame, returns to PAUSED on next vblank or timeout
module pause_frame_ctrl
  import pause_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
  parameter int VB_TIMEOUT_CYC = VB_TIMEOUT_CYC_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic button_raw,
  input  logic step_raw,
  input  logic vblank,
  output logic pause_request,
  output logic paused,
  output logic forced
);

  localparam int TW = $clog2(VB_TIMEOUT_CYC + 1);

  pause_state_e  state;
  pause_state_e  state_nxt;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          btn_press;
  logic          step_press;
  logic          vb_q;
  logic          vb_rise;
  logic          forced_nxt;

  pause_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .btn_raw (button_raw),
    .press   (btn_press)
  );

`ifdef PAUSE_FRAME_STEP_EN
  pause_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .btn_raw (step_raw),
    .press   (step_press)
  );
`else
  logic step_unused;
  assign step_unused = step_raw;
  assign step_press  = 1'b0;
`endif

  assign vb_rise = vblank & ~vb_q;
  assign tmo_hit = (tmo == TW'(VB_TIMEOUT_CYC - 1));
  assign paused  = (state == PAUSED);

  // Button always wins; vblank beats a simultaneous timeout so forced stays clear.
  always_comb begin
    state_nxt  = state;
    forced_nxt = forced;
    unique case (state)
      RUN: begin
        if (btn_press) state_nxt = ARM;
      end
      ARM, STEP: begin
        if (btn_press) begin
          state_nxt = RUN;
        end else if (vb_rise) begin
          state_nxt  = PAUSED;
          forced_nxt = 1'b0;
        end else if (tmo_hit) begin
          state_nxt  = PAUSED;
          forced_nxt = 1'b1;
        end
      end
      PAUSED: begin
        if (btn_press)       state_nxt = RUN;
        else if (step_press) state_nxt = STEP;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RUN;
      tmo           <= '0;
      vb_q          <= 1'b0;
      pause_request <= 1'b0;
      forced        <= 1'b0;
    end else begin
      state         <= state_nxt;
      forced        <= forced_nxt;
      vb_q          <= vblank;
      pause_request <= (state == PAUSED);
      if (state_nxt != state) begin
        tmo <= '0;
      end else if ((state == ARM || state == STEP) && tmo != TW'(VB_TIMEOUT_CYC)) begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pause_frame_ctrl.sv
// Directed bench for pause_frame_ctrl with DEBOUNCE_CYC=4, VB_TIMEOUT_CYC=50.
module tb_pause_frame_ctrl;
  import pause_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic button_raw;
  logic step_raw;
  logic vblank;
  logic pause_request;
  logic paused;
  logic forced;

  int n_cmp = 0;
  int n_err = 0;

  pause_frame_ctrl #(.DEBOUNCE_CYC(4), .VB_TIMEOUT_CYC(50)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .button_raw    (button_raw),
    .step_raw      (step_raw),
    .vblank        (vblank),
    .pause_request (pause_request),
    .paused        (paused),
    .forced        (forced)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    button_raw = 1'b0;
    step_raw   = 1'b0;
    vblank     = 1'b0;
    tick(3);
    check("rst_state", 32'(dut.state), 32'(RUN));
    check("rst_preq", 32'(pause_request), 0);
    check("rst_paused", 32'(paused), 0);
    check("rst_forced", 32'(forced), 0);
    reset_n = 1'b1;
    tick(5);

    // 3-cycle glitch is rejected
    button_raw = 1'b1;
    tick(3);
    button_raw = 1'b0;
    tick(10);
    check("glitch_state", 32'(dut.state), 32'(RUN));
    check("glitch_preq", 32'(pause_request), 0);

    // held press, then vblank rise -> PAUSED with forced clear
    button_raw = 1'b1;
    tick(6);
    check("press_pulse", 32'(dut.btn_press), 1);
    check("press_still_run", 32'(dut.state), 32'(RUN));
    tick(1);
    check("arm_entry", 32'(dut.state), 32'(ARM));
    tick(3);
    button_raw = 1'b0;
    tick(20);
    check("arm_wait", 32'(dut.state), 32'(ARM));
    check("arm_preq", 32'(pause_request), 0);
    vblank = 1'b1;
    tick(1);
    check("vb_paused", 32'(paused), 1);
    check("vb_preq_lat", 32'(pause_request), 0);
    check("vb_forced", 32'(forced), 0);
    tick(1);
    check("vb_preq", 32'(pause_request), 1);
    tick(3);
    vblank = 1'b0;

    // resume
    button_raw = 1'b1;
    tick(7);
    check("resume_state", 32'(dut.state), 32'(RUN));
    check("resume_paused", 32'(paused), 0);
    check("resume_preq_lat", 32'(pause_request), 1);
    tick(1);
    check("resume_preq", 32'(pause_request), 0);
    button_raw = 1'b0;
    tick(10);

    // timeout path: 50 cycles in ARM
    button_raw = 1'b1;
    tick(7);
    check("to_arm", 32'(dut.state), 32'(ARM));
    button_raw = 1'b0;
    tick(49);
    check("to_arm_49", 32'(dut.state), 32'(ARM));
    tick(1);
    check("to_paused", 32'(paused), 1);
    check("to_forced", 32'(forced), 1);
    tick(1);
    check("to_preq", 32'(pause_request), 1);
    button_raw = 1'b1;
    tick(7);
    check("to_resume", 32'(dut.state), 32'(RUN));
    check("forced_sticky", 32'(forced), 1);
    button_raw = 1'b0;
    tick(10);

    // button press in the same cycle as vb_rise cancels
    button_raw = 1'b1;
    tick(7);
    check("cancel_arm", 32'(dut.state), 32'(ARM));
    button_raw = 1'b0;
    tick(8);
    button_raw = 1'b1;
    tick(6);
    check("cancel_pulse", 32'(dut.btn_press), 1);
    vblank = 1'b1;
    tick(1);
    check("cancel_state", 32'(dut.state), 32'(RUN));
    check("cancel_paused", 32'(paused), 0);
    check("cancel_forced", 32'(forced), 1);
    tick(3);
    check("cancel_preq", 32'(pause_request), 0);
    vblank     = 1'b0;
    button_raw = 1'b0;
    tick(10);

    // back into PAUSED via vblank
    button_raw = 1'b1;
    tick(7);
    button_raw = 1'b0;
    tick(10);
    vblank = 1'b1;
    tick(1);
    check("p2_paused", 32'(paused), 1);
    check("p2_forced", 32'(forced), 0);
    tick(2);
    vblank = 1'b0;

`ifdef PAUSE_FRAME_STEP_EN
    step_raw = 1'b1;
    tick(7);
    check("step_entry", 32'(dut.state), 32'(STEP));
    check("step_paused", 32'(paused), 0);
    check("step_preq_lat", 32'(pause_request), 1);
    tick(1);
    check("step_preq", 32'(pause_request), 0);
    step_raw = 1'b0;
    tick(20);
    check("step_wait", 32'(dut.state), 32'(STEP));
    check("step_wait_preq", 32'(pause_request), 0);
    tick(2);
    vblank = 1'b1;
    tick(1);
    check("step_back_paused", 32'(paused), 1);
    check("step_back_forced", 32'(forced), 0);
    tick(1);
    check("step_back_preq", 32'(pause_request), 1);
    vblank = 1'b0;

    step_raw = 1'b1;
    tick(7);
    check("step_to_entry", 32'(dut.state), 32'(STEP));
    step_raw = 1'b0;
    tick(49);
    check("step_to_49", 32'(dut.state), 32'(STEP));
    tick(1);
    check("step_to_paused", 32'(paused), 1);
    check("step_to_forced", 32'(forced), 1);

    step_raw = 1'b1;
    tick(7);
    check("step_rst_entry", 32'(dut.state), 32'(STEP));
    step_raw   = 1'b0;
`else
    step_raw = 1'b1;
    tick(10);
    check("step_ignored", 32'(dut.state), 32'(PAUSED));
    check("step_ignored_preq", 32'(pause_request), 1);
    step_raw = 1'b0;
    tick(8);
`endif

    // async reset with button held; no press until re-pressed
    button_raw = 1'b1;
    tick(2);
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(dut.state), 32'(RUN));
    check("arst_paused", 32'(paused), 0);
    check("arst_preq", 32'(pause_request), 0);
    check("arst_forced", 32'(forced), 0);
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check("held_level", 32'(dut.u_btn.level), 1);
    check("held_no_press", 32'(dut.state), 32'(RUN));
    button_raw = 1'b0;
    tick(10);
    button_raw = 1'b1;
    tick(7);
    check("repress_arm", 32'(dut.state), 32'(ARM));
    button_raw = 1'b0;
    tick(10);
    button_raw = 1'b1;
    tick(7);
    check("arm_cancel", 32'(dut.state), 32'(RUN));
    button_raw = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pause_frame_ctrl.md
PAUSE_FRAME_CTRL -- requirements
Module: pause_frame_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 120000, cycles an input must hold stable before acceptance (10 ms @ 12 MHz).
REQ-002 SHALL have parameter VB_TIMEOUT_CYC, default 1200000, max cycles to wait for vblank before forcing pause (100 ms @ 12 MHz).
REQ-003 SHALL have port clk_sys, input, 1, core system clock; the only clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port button_raw, input, 1, raw pause button, asynchronous, active-high.
REQ-006 SHALL have port step_raw, input, 1, raw frame-step button, asynchronous, active-high.
REQ-007 SHALL have port vblank, input, 1, core vertical blank, synchronous to clk_sys, active-high.
REQ-008 SHALL have port pause_request, output, 1, active-high; drives the downstream pause block's pause_request input.
REQ-009 SHALL have port paused, output, 1, high only in state PAUSED.
REQ-010 SHALL have port forced, output, 1, sticky flag: last pause entry was by timeout, not vblank.

Function
REQ-011 SHALL pass button_raw and step_raw through a 2-FF synchronizer, then a debouncer; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles.
REQ-012 SHALL produce one-cycle press pulses on debounced 0->1 transitions; releases generate nothing.
REQ-013 SHALL detect vblank rising edge (vb_rise) as vblank high and registered vblank low.
REQ-014 SHALL implement states RUN, ARM, PAUSED, STEP.
REQ-015 RUN: on button press -> ARM, timeout counter cleared; step press ignored.
REQ-016 ARM: on vb_rise -> PAUSED, forced<=0; on counter reaching VB_TIMEOUT_CYC-1 -> PAUSED, forced<=1; on button press -> RUN (cancel); button press wins over simultaneous vb_rise or timeout.
REQ-017 PAUSED: on button press -> RUN (immediate resume, next cycle); on step press -> STEP, timeout counter cleared; button wins over simultaneous step.
REQ-018 STEP: on vb_rise or timeout -> PAUSED (forced set by same rule as ARM); on button press -> RUN; vb_rise in the cycle of STEP entry is not consumed.
REQ-019 pause_request SHALL be registered, high in PAUSED only; ARM and STEP keep it low; one cycle latency from state change.
REQ-020 timeout counter SHALL saturate, count only in ARM/STEP, and clear on every state entry; width $clog2(VB_TIMEOUT_CYC+1).
REQ-021 forced SHALL hold its value until the next entry into PAUSED.

Reset
REQ-022 On reset_n low SHALL asynchronously set state RUN, pause_request 0, paused 0, forced 0, all counters 0, synchronizers and debounced levels 0.
REQ-023 Reset mid-ARM/STEP/PAUSED SHALL return to RUN; a button held across reset release SHALL NOT generate a press until released and re-pressed.

Configuration
REQ-024 Macro PAUSE_FRAME_STEP_EN: defined -> step_raw path and STEP state present as above; undefined -> step_raw ignored, no step debouncer, STEP state unreachable, PAUSED exits only via button.

Structure
REQ-025 SHALL place state encoding enum (RUN=0, ARM=1, PAUSED=2, STEP=3) and default cycle constants in shared package pause_pkg.
REQ-026 SHALL use sub-module pause_debounce (synchronizer + debounce + press pulse), instantiated once per button.

Verification (DEBOUNCE_CYC=4, VB_TIMEOUT_CYC=50)
REQ-027 Button glitch high 3 cycles -> no press, state RUN, pause_request 0.
REQ-028 Button held 10 cycles, vblank rise 20 cycles later -> ARM then PAUSED; pause_request 1 one cycle after vb_rise; forced 0.
REQ-029 Button press, vblank held low -> PAUSED after 50 cycles in ARM, forced 1, pause_request 1.
REQ-030 With PAUSE_FRAME_STEP_EN, in PAUSED press step, vblank rise 30 cycles later -> pause_request 0 for that window, then 1; paused back to 1.
REQ-031 Button press same cycle as vb_rise in ARM -> RUN, pause_request stays 0.
REQ-032 reset_n low mid-STEP with button held -> RUN immediately, outputs 0; no press until button released and re-pressed.
